// File: rtl/add_one_driver_if.sv
// rtl/add_one_driver_if.sv - request/result handshake channels between the add-one driver and its responder
// Both channels transfer on vld=1 and busy=0 at the rising edge.
interface add_one_driver_if #(
    parameter int WIDTH = 32
);
    logic             add_one_x_vld;
    logic [WIDTH-1:0] add_one_x_data;
    logic             add_one_x_busy;
    logic             add_one_return_vld;
    logic [WIDTH-1:0] add_one_return_data;
    logic             add_one_return_busy;

    modport master (
        output add_one_x_vld,
        output add_one_x_data,
        input  add_one_x_busy,
        input  add_one_return_vld,
        input  add_one_return_data,
        output add_one_return_busy
    );

    modport slave (
        input  add_one_x_vld,
        input  add_one_x_data,
        output add_one_x_busy,
        output add_one_return_vld,
        output add_one_return_data,
        input  add_one_return_busy
    );
endinterface

// File: rtl/add_one_driver.sv
// rtl/add_one_driver.sv - issues an incrementing operand stream and checks each result equals operand+1
// Expected operands wait in a DEPTH-entry FIFO; results are assumed to return in request order.
module add_one_driver #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    start_val,
    input  logic [15:0]         count,
    output logic                done,
    output logic [15:0]         err_cnt,
    output logic                pass,
    add_one_driver_if.master    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   next_val_q, next_val_d;
    logic [15:0]        sent_q, sent_d;
    logic [15:0]        recvd_q, recvd_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     occ_q, occ_d;
    logic [WIDTH-1:0]   fifo_mem [DEPTH];

    logic               fifo_full;
    logic               fifo_empty;
    logic               x_vld;
    logic               ret_busy;
    logic               x_fire;
    logic               ret_fire;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   expected;

    assign fifo_full  = (occ_q == OCC_FULL);
    assign fifo_empty = (occ_q == '0);

    // Valid depends only on registered state, so it cannot drop while the consumer stalls.
    assign x_vld    = (state_q == ST_RUN) && (sent_q < count_q) && !fifo_full;
    assign ret_busy = !((state_q == ST_RUN) && !fifo_empty);

    assign bus.add_one_x_vld       = x_vld;
    assign bus.add_one_x_data      = next_val_q;
    assign bus.add_one_return_busy = ret_busy;

    assign x_fire   = x_vld && !bus.add_one_x_busy;
    assign ret_fire = bus.add_one_return_vld && !ret_busy;
    assign expected = fifo_mem[rd_ptr_q] + WIDTH'(1);

    assign done    = (state_q == ST_DONE);
    assign err_cnt = err_cnt_q;
    assign pass    = done && (err_cnt_q == 16'd0);

    always_comb begin
        state_d    = state_q;
        next_val_d = next_val_q;
        sent_d     = sent_q;
        recvd_d    = recvd_q;
        count_d    = count_q;
        err_cnt_d  = err_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        push       = 1'b0;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_val_d = start_val;
                    sent_d     = 16'd0;
                    recvd_d    = 16'd0;
                    count_d    = count;
                    err_cnt_d  = 16'd0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    occ_d      = '0;
                    state_d    = (count == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                push = x_fire;
                pop  = ret_fire;
                if (push) begin
                    next_val_d = next_val_q + WIDTH'(1);
                    sent_d     = sent_q + 16'd1;
                    wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    recvd_d  = recvd_q + 16'd1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if ((expected != bus.add_one_return_data) && (err_cnt_q != 16'hFFFF)) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if ((recvd_q + 16'd1) == count_q) begin
                        state_d = ST_DONE;
                    end
                end
                if (push && !pop) begin
                    occ_d = occ_q + (PTR_W + 1)'(1);
                end else if (pop && !push) begin
                    occ_d = occ_q - (PTR_W + 1)'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            next_val_q <= '0;
            sent_q     <= 16'd0;
            recvd_q    <= 16'd0;
            count_q    <= 16'd0;
            err_cnt_q  <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            next_val_q <= next_val_d;
            sent_q     <= sent_d;
            recvd_q    <= recvd_d;
            count_q    <= count_d;
            err_cnt_q  <= err_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // Storage needs no reset: occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= next_val_q;
        end
    end
endmodule
